// File: rtl/l2_bus_txn_unit.sv
// L2 downstream bus stage: one READ/WRITE/INVALIDATE/RWIM at a time through ADDR, SNOOP, DATA and RESP.
// Latency: INVALIDATE SNOOP_LAT+1, READ with ack high SNOOP_LAT+2; req_ready only in IDLE, RESP held until rsp_ready.
module l2_bus_txn_unit #(
  parameter int ADDR_W    = 32,
  parameter int OFFSET_W  = 6,
  parameter int SNOOP_LAT = 2,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_snoop,
  output logic              rsp_err,
  output logic              bus_valid,
  output logic [2:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [1:0]        snoop_in,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  cnt_read,
  output logic [CNT_W-1:0]  cnt_write,
  output logic [CNT_W-1:0]  cnt_inval,
  output logic [CNT_W-1:0]  cnt_rwim
);

  localparam logic [2:0]        OP_READ   = 3'd1;
  localparam logic [2:0]        OP_WRITE  = 3'd2;
  localparam logic [2:0]        OP_INVAL  = 3'd3;
  localparam logic [2:0]        OP_RWIM   = 3'd4;
  localparam logic [1:0]        SNP_NOHIT = 2'b10;
  localparam logic [7:0]        SNOOP_LD  = 8'(SNOOP_LAT - 1);
  localparam logic [7:0]        TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_SNOOP,
    S_DATA,
    S_RESP
  } state_t;

  state_t     state;
  logic [2:0] op;
  logic [7:0] dly;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op        <= 3'd0;
      dly       <= 8'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_snoop <= SNP_NOHIT;
      rsp_err   <= 1'b0;
      bus_valid <= 1'b0;
      bus_op    <= 3'd0;
      bus_addr  <= '0;
      cnt_read  <= '0;
      cnt_write <= '0;
      cnt_inval <= '0;
      cnt_rwim  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op        <= req_op;
            req_ready <= 1'b0;
            if (req_op >= OP_READ && req_op <= OP_RWIM) begin
              state     <= S_ADDR;
              bus_valid <= 1'b1;
              bus_op    <= req_op;
              bus_addr  <= req_addr & LINE_MASK;
            end else begin
              // Illegal op: answer with an error and never touch the bus.
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_snoop <= SNP_NOHIT;
            end
          end
        end
        S_ADDR: begin
          bus_valid <= 1'b0;
          dly       <= SNOOP_LD;
          state     <= S_SNOOP;
        end
        S_SNOOP: begin
          if (dly == 8'd0) begin
            rsp_snoop <= (snoop_in == 2'b11) ? SNP_NOHIT : snoop_in;
            if (op == OP_INVAL) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
            end else begin
              state <= S_DATA;
              dly   <= 8'd0;
            end
          end else begin
            dly <= dly - 8'd1;
          end
        end
        S_DATA: begin
          // An ack arriving in the last allowed cycle still wins over the timeout.
          if (mem_ack) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
          end else if (dly == TO_LAST) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            dly <= dly + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_snoop <= SNP_NOHIT;
            req_ready <= 1'b1;
            bus_op    <= 3'd0;
            bus_addr  <= '0;
            if (!rsp_err) begin
              case (op)
                OP_READ:  cnt_read  <= sat_inc(cnt_read);
                OP_WRITE: cnt_write <= sat_inc(cnt_write);
                OP_INVAL: cnt_inval <= sat_inc(cnt_inval);
                OP_RWIM:  cnt_rwim  <= sat_inc(cnt_rwim);
                default: ;
              endcase
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_bus_txn_unit.sv
// Bench for l2_bus_txn_unit: vector table, reset/saturation sequences and randomized transactions vs a latency model.
module tb_l2_bus_txn_unit;

  localparam int AW    = 32;
  localparam int OW    = 6;
  localparam int SL    = 2;
  localparam int TO    = 16;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int NEVER = 100000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'd0;
  logic [AW-1:0] req_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_snoop;
  logic          rsp_err;
  logic          bus_valid;
  logic [2:0]    bus_op;
  logic [AW-1:0] bus_addr;
  logic [1:0]    snoop_in = 2'b10;
  logic          mem_ack = 1'b0;
  logic [CW-1:0] cnt_read, cnt_write, cnt_inval, cnt_rwim;

  always #5 clk = ~clk;

  l2_bus_txn_unit #(
    .ADDR_W(AW), .OFFSET_W(OW), .SNOOP_LAT(SL), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_snoop(rsp_snoop), .rsp_err(rsp_err),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .snoop_in(snoop_in), .mem_ack(mem_ack),
    .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_inval(cnt_inval), .cnt_rwim(cnt_rwim)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt[5];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [1:0]  snp;
    int          ack_start;
    int          rdy_wait;
    int          exp_lat;
    logic [1:0]  exp_snoop;
    logic        exp_err;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_counters();
    chk("cnt_read",  32'(cnt_read),  32'(exp_cnt[1]));
    chk("cnt_write", 32'(cnt_write), 32'(exp_cnt[2]));
    chk("cnt_inval", 32'(cnt_inval), 32'(exp_cnt[3]));
    chk("cnt_rwim",  32'(cnt_rwim),  32'(exp_cnt[4]));
  endtask

  // Reference: latency counted in clock edges after the accepting edge until rsp_valid is visible.
  task automatic model(input logic [2:0] op, input logic [1:0] snp, input int ack_start,
                       output int lat, output logic [1:0] s, output logic e);
    int k;
    if (op == 3'd0 || op > 3'd4) begin
      lat = 0; s = 2'b10; e = 1'b1;
    end else begin
      s = (snp == 2'b11) ? 2'b10 : snp;
      if (op == 3'd3) begin
        lat = SL + 1; e = 1'b0;
      end else begin
        k = ack_start - SL;
        if (k < 1) k = 1;
        if (k > TO) begin
          lat = SL + 1 + TO; e = 1'b1;
        end else begin
          lat = SL + 1 + k; e = 1'b0;
        end
      end
    end
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] snp,
                         input int ack_start, input int rdy_wait, input int exp_lat,
                         input logic [1:0] exp_snoop, input logic exp_err, input logic [31:0] exp_addr);
    int c;
    int bv;
    bit bus_bad;
    bit hold_bad;
    bit got;
    bit legal;
    legal = (op >= 3'd1 && op <= 3'd4);
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    snoop_in  = 2'($urandom_range(0, 3));
    mem_ack   = (ack_start <= 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom_range(0, 7));
    req_addr  = $urandom;
    c = 0; bv = 0; bus_bad = 0; got = 0;
    while (!got && c < SL + TO + 10) begin
      if (rsp_valid === 1'b1) begin
        got = 1;
      end else begin
        if (bus_valid === 1'b1) bv++;
        if (legal && (bus_op !== op || bus_addr !== exp_addr)) bus_bad = 1;
        snoop_in = (c == SL) ? snp : 2'($urandom_range(0, 3));
        mem_ack  = (c >= ack_start);
        @(posedge clk); #1;
        c++;
      end
    end
    if (!got) begin
      chk("rsp_arrives", 32'd0, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
      return;
    end
    chk("latency", 32'(c), 32'(exp_lat));
    chk("bus_valid_pulses", 32'(bv), legal ? 32'd1 : 32'd0);
    chk("bus_stable", 32'(bus_bad), 32'd0);
    chk("rsp_snoop", 32'(rsp_snoop), 32'(exp_snoop));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    hold_bad = 0;
    for (int i = 0; i < rdy_wait; i++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_op    = 3'd1;
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || bus_valid !== 1'b0 ||
          rsp_snoop !== exp_snoop || rsp_err !== exp_err) hold_bad = 1;
    end
    if (rdy_wait > 0) chk("resp_hold", 32'(hold_bad), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    if (!exp_err && legal && exp_cnt[op] < CMAX) exp_cnt[op]++;
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_bus_valid", 32'(bus_valid), 32'd0);
    chk("post_bus_op", 32'(bus_op), 32'd0);
    chk("post_bus_addr", bus_addr, 32'd0);
    check_counters();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [1:0] es;
    logic ee;
    logic [2:0] rop;
    logic [31:0] raddr;
    logic [1:0] rsnp;
    int rack;
    bit quiet_bad;

    vecs[0] = '{3'd1, 32'h1234_5678, 2'b00, SL + 3,   0,  6,  2'b00, 1'b0, 32'h1234_5640};
    vecs[1] = '{3'd3, 32'hA000_007F, 2'b01, NEVER,    1,  3,  2'b01, 1'b0, 32'hA000_0040};
    vecs[2] = '{3'd4, 32'hDEAD_BEEF, 2'b10, NEVER,    0,  19, 2'b10, 1'b1, 32'hDEAD_BEC0};
    vecs[3] = '{3'd4, 32'h0000_0FFF, 2'b00, SL + TO,  0,  19, 2'b00, 1'b0, 32'h0000_0FC0};
    vecs[4] = '{3'd5, 32'h5555_5555, 2'b00, 0,        10, 0,  2'b10, 1'b1, 32'h0000_0000};
    vecs[5] = '{3'd1, 32'h0000_0040, 2'b11, 0,        2,  4,  2'b10, 1'b0, 32'h0000_0040};
    vecs[6] = '{3'd2, 32'hFFFF_FFFF, 2'b00, 0,        0,  4,  2'b00, 1'b0, 32'hFFFF_FFC0};
    vecs[7] = '{3'd0, 32'h0000_0001, 2'b01, 0,        3,  0,  2'b10, 1'b1, 32'h0000_0000};
    vecs[8] = '{3'd4, 32'h8000_0001, 2'b01, 17,       0,  18, 2'b01, 1'b0, 32'h8000_0000};
    for (int i = 0; i < 5; i++) exp_cnt[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_snoop", 32'(rsp_snoop), 32'd2);
    chk("reset_bus_valid", 32'(bus_valid), 32'd0);
    chk("reset_bus_op", 32'(bus_op), 32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    check_counters();

    foreach (vecs[i])
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].snp, vecs[i].ack_start, vecs[i].rdy_wait,
              vecs[i].exp_lat, vecs[i].exp_snoop, vecs[i].exp_err, vecs[i].exp_addr);

    // Reset held two cycles while a READ sits in DATA waiting for an ack.
    req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h0BAD_F00D; mem_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (SL + 3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_bus_addr", bus_addr, 32'd0);
    check_counters();
    quiet_bad = 0;
    mem_ack = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || bus_valid !== 1'b0 || req_ready !== 1'b1) quiet_bad = 1;
    end
    mem_ack = 1'b0;
    chk("midreset_no_response", 32'(quiet_bad), 32'd0);

    // Back-to-back WRITEs drive cnt_write to saturation.
    for (int i = 0; i < CMAX + 2; i++)
      run_txn(3'd2, 32'h0000_1000 + 32'(i * 64), 2'b10, 0, 0, SL + 2, 2'b10, 1'b0,
              32'h0000_1000 + 32'(i * 64));
    chk("cnt_write_saturated", 32'(cnt_write), 32'(CMAX));

    for (int n = 0; n < 60; n++) begin
      rop   = ($urandom_range(0, 7) != 0) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(5, 7));
      if ($urandom_range(0, 9) == 0) rop = 3'd0;
      raddr = $urandom;
      rsnp  = 2'($urandom_range(0, 3));
      rack  = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, SL + TO + 2));
      model(rop, rsnp, rack, lat, es, ee);
      run_txn(rop, raddr, rsnp, rack, int'($urandom_range(0, 3)), lat, es, ee,
              raddr & 32'hFFFF_FFC0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
